ready_sync_gen: RTL and testbench

//  Multi-player ready synchroniser and start-number generator for the factorization game.
//  - Latches each player's READY pulse.
//  - Starts a round once all players are ready.
//  - Captures a free-running 0..NUM_MAX tick counter as the round's start number.
//  - Holds RUN_IN high until the game FSM reports a win or lose state.

---
 rtl/ready_pkg.sv | 22 ++
 rtl/tick_prescaler.sv | 30 +++
 rtl/ready_sync_gen.sv | 125 ++++++++++++
 tb/tb_ready_sync_gen.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/ready_pkg.sv
// Shared types and helpers for the ready synchroniser and its tick prescaler.
package ready_pkg;

    typedef enum logic [1:0] {
        WAIT,
        START,
        RUN,
        DONE
    } state_t;

    localparam int DEF_CLK_HZ  = 50_000_000;
    localparam int DEF_TICK_HZ = 1;

    function automatic int div_of(input int clk_hz, input int tick_hz);
        return clk_hz / tick_hz;
    endfunction

    function automatic int div_w(input int div);
        return $clog2(div);
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running prescaler: TICK is high for one clock out of every CLK_HZ/TICK_HZ clocks.
module tick_prescaler
    import ready_pkg::*;
#(
    parameter int CLK_HZ  = DEF_CLK_HZ,
    parameter int TICK_HZ = DEF_TICK_HZ
) (
    input  logic CLK,
    input  logic RST,
    output logic TICK
);

    localparam int DIV   = div_of(CLK_HZ, TICK_HZ);
    localparam int CNT_W = div_w(DIV);

    logic [CNT_W-1:0] cnt;

    assign TICK = (cnt == CNT_W'(DIV - 1));

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt <= '0;
        end else if (TICK) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/ready_sync_gen.sv
// Player ready synchroniser and round start-number generator for the factorization game.
// Optional feature macro: READY_TIMEOUT_EN (drops partial ready sets after TIMEOUT_TICKS ticks).
module ready_sync_gen
    import ready_pkg::*;
#(
    parameter int                 NUM_PLAYERS   = 2,
    parameter int                 CLK_HZ        = DEF_CLK_HZ,
    parameter int                 TICK_HZ       = DEF_TICK_HZ,
    parameter int                 NUM_MAX       = 9,
    parameter int                 NUM_W         = 4,
    parameter int                 STATE_W       = 4,
    parameter logic [STATE_W-1:0] WIN_STATE     = 4'hE,
    parameter logic [STATE_W-1:0] LOSE_STATE    = 4'hF,
    parameter int                 TIMEOUT_TICKS = 10
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [NUM_PLAYERS-1:0] READY,
    input  logic [STATE_W-1:0]     STATE,
    output logic                   RUN_IN,
    output logic [NUM_W-1:0]       NUM,
    output logic                   NUM_VALID,
    output logic [NUM_PLAYERS-1:0] READY_Q,
    output logic                   TICK,
    output logic                   TIMEOUT
);

    state_t           state;
    logic [NUM_W-1:0] seq;
    logic             all_ready;

    tick_prescaler #(
        .CLK_HZ  (CLK_HZ),
        .TICK_HZ (TICK_HZ)
    ) u_tick (
        .CLK  (CLK),
        .RST  (RST),
        .TICK (TICK)
    );

    // The completing READY counts in the same cycle it arrives.
    assign all_ready = &(READY_Q | READY);

    always_ff @(posedge CLK) begin
        if (RST) begin
            seq <= '0;
        end else if (TICK) begin
            seq <= (seq == NUM_W'(NUM_MAX)) ? '0 : seq + 1'b1;
        end
    end

`ifdef READY_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_TICKS + 1);

    logic [TMO_W-1:0] tmo_cnt;
    logic             partial;
    logic             tmo_hit;

    assign partial = (state == WAIT) && (READY_Q != '0) && !(&READY_Q);
    assign tmo_hit = partial && TICK && (tmo_cnt == TMO_W'(TIMEOUT_TICKS - 1));

    always_ff @(posedge CLK) begin
        if (RST) begin
            tmo_cnt <= '0;
            TIMEOUT <= 1'b0;
        end else begin
            // A set that completes on the timeout tick starts the round instead of being dropped.
            TIMEOUT <= tmo_hit && !all_ready;
            if (!partial || all_ready || tmo_hit) begin
                tmo_cnt <= '0;
            end else if (TICK) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
        end
    end
`else
    logic [31:0] unused_timeout_ticks;

    assign unused_timeout_ticks = 32'(TIMEOUT_TICKS);
    assign TIMEOUT              = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= WAIT;
            RUN_IN    <= 1'b0;
            NUM       <= '0;
            NUM_VALID <= 1'b0;
            READY_Q   <= '0;
        end else begin
            NUM_VALID <= 1'b0;
            case (state)
                WAIT: begin
                    // NOTE: a later non-blocking assignment in the same block overrides this default.
                    READY_Q <= READY_Q | READY;
                    if (all_ready) begin
                        state <= START;
`ifdef READY_TIMEOUT_EN
                    end else if (tmo_hit) begin
                        READY_Q <= '0;
`endif
                    end
                end
                START: begin
                    NUM       <= seq;
                    NUM_VALID <= 1'b1;
                    RUN_IN    <= 1'b1;
                    state     <= RUN;
                end
                RUN: begin
                    if (STATE == WIN_STATE || STATE == LOSE_STATE) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    RUN_IN  <= 1'b0;
                    READY_Q <= '0;
                    state   <= WAIT;
                end
                default: state <= WAIT;
            endcase
        end
    end

endmodule

// File: tb/tb_ready_sync_gen.sv
// Self-checking bench for ready_sync_gen: timestamp-based reference model plus directed literal checks.
// Build with READY_TIMEOUT_EN defined to exercise the timeout variant.
module tb_ready_sync_gen;

    localparam int DIV      = 10;
    localparam int NUM_MOD  = 10;
    localparam int TMO      = 3;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [1:0] READY = 2'b00;
    logic [3:0] STATE = 4'h0;
    logic       RUN_IN;
    logic [3:0] NUM;
    logic       NUM_VALID;
    logic [1:0] READY_Q;
    logic       TICK;
    logic       TIMEOUT;

    int n_checks = 0;
    int n_fail   = 0;

    ready_sync_gen #(
        .NUM_PLAYERS   (2),
        .CLK_HZ        (10),
        .TICK_HZ       (1),
        .NUM_MAX       (9),
        .NUM_W         (4),
        .STATE_W       (4),
        .WIN_STATE     (4'hE),
        .LOSE_STATE    (4'hF),
        .TIMEOUT_TICKS (TMO)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .READY     (READY),
        .STATE     (STATE),
        .RUN_IN    (RUN_IN),
        .NUM       (NUM),
        .NUM_VALID (NUM_VALID),
        .READY_Q   (READY_Q),
        .TICK      (TICK),
        .TIMEOUT   (TIMEOUT)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: everything is a function of cycles since reset and round timestamps.
    bit         model_ok = 0;
    int         m_cyc    = 0;   // cycles since the last reset edge
    bit         m_active = 0;   // a round is in progress (ready set completed, not yet back to waiting)
    int         m_c      = 0;   // cycle in which the ready set completed
    int         m_e      = -1;  // cycle in which an end state was first honoured
    logic [1:0] m_lat    = 2'b00;
    logic [3:0] m_num    = 4'h0;
    int         m_tcnt   = 0;
    int         m_tmo_at = -1;

    function automatic int seq_of(input int c);
        return (c / DIV) % NUM_MOD;
    endfunction

    function automatic bit tick_of(input int c);
        return (c % DIV) == DIV - 1;
    endfunction

    always @(negedge CLK) begin
        if (model_ok) begin
            check("TICK", 32'(TICK), 32'(tick_of(m_cyc)));
            check("RUN_IN", 32'(RUN_IN),
                  32'(m_active && m_cyc >= m_c + 2 && (m_e < 0 || m_cyc <= m_e + 1)));
            check("NUM_VALID", 32'(NUM_VALID), 32'(m_active && m_cyc == m_c + 2));
            check("NUM", 32'(NUM), 32'(m_num));
            check("READY_Q", 32'(READY_Q), 32'(m_lat));
            check("TIMEOUT", 32'(TIMEOUT), 32'(m_cyc == m_tmo_at));
        end
        if (RST) begin
            model_ok = 1;
            m_cyc    = 0;
            m_active = 0;
            m_e      = -1;
            m_lat    = 2'b00;
            m_num    = 4'h0;
            m_tcnt   = 0;
            m_tmo_at = -1;
        end else if (model_ok) begin
            if (m_active) begin
                if (m_cyc == m_c + 1) m_num = 4'(seq_of(m_cyc));
                if (m_e >= 0 && m_cyc == m_e + 1) begin
                    m_active = 0;
                    m_lat    = 2'b00;
                end else if (m_e < 0 && m_cyc >= m_c + 2 && (STATE == 4'hE || STATE == 4'hF)) begin
                    m_e = m_cyc;
                end
            end else if ((m_lat | READY) == 2'b11) begin
                m_active = 1;
                m_c      = m_cyc;
                m_e      = -1;
                m_lat    = 2'b11;
                m_tcnt   = 0;
            end else begin
`ifdef READY_TIMEOUT_EN
                if (m_lat == 2'b00) m_tcnt = 0;
                else if (tick_of(m_cyc)) m_tcnt++;
                if (m_tcnt == TMO) begin
                    m_lat    = 2'b00;
                    m_tcnt   = 0;
                    m_tmo_at = m_cyc + 1;
                end else begin
                    m_lat = m_lat | READY;
                end
`else
                m_lat = m_lat | READY;
`endif
            end
            m_cyc++;
        end
    end

    task automatic go(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    int r;
    int ticks;

    initial begin
        // Reset, then 100 idle cycles: exactly ten ticks, no round activity.
        go(2);
        RST = 1'b0;
        check("reset RUN_IN", 32'(RUN_IN), 32'd0);
        check("reset NUM", 32'(NUM), 32'd0);
        check("reset READY_Q", 32'(READY_Q), 32'd0);
        ticks = 0;
        for (int i = 0; i < 100; i++) begin
            if (TICK) ticks++;
            go(1);
        end
        check("ticks in 100 clks", 32'(ticks), 32'd10);

        // Staggered ready pulses; the second lands while seq is 4.
        go(25);
        READY = 2'b01;
        go(1);
        READY = 2'b00;
        go(14);
        READY = 2'b10;
        go(1);
        READY = 2'b00;
        check("ready latched", 32'(READY_Q), 32'h3);
        check("run not yet", 32'(RUN_IN), 32'd0);
        go(1);
        check("run high", 32'(RUN_IN), 32'd1);
        check("start num 4", 32'(NUM), 32'd4);
        check("num_valid pulse", 32'(NUM_VALID), 32'd1);
        go(1);
        check("num_valid drop", 32'(NUM_VALID), 32'd0);

        // READY ignored in RUN; a win state ends the round two clocks later.
        READY = 2'b11;
        go(1);
        READY = 2'b00;
        check("ready ignored in run", 32'(READY_Q), 32'h3);
        go(2);
        STATE = 4'hE;
        go(1);
        STATE = 4'h0;
        check("run held in done", 32'(RUN_IN), 32'd1);
        go(1);
        check("run fell", 32'(RUN_IN), 32'd0);
        check("ready cleared", 32'(READY_Q), 32'd0);
        check("num held", 32'(NUM), 32'd4);

        // Completion on the tick where seq wraps 9 -> 0; end state during START is ignored.
        go(51);
        check("tick at seq 9", 32'(TICK), 32'd1);
        READY = 2'b11;
        go(1);
        READY = 2'b00;
        STATE = 4'hF;
        go(1);
        STATE = 4'h0;
        check("wrap num 0", 32'(NUM), 32'd0);
        check("wrap run high", 32'(RUN_IN), 32'd1);
        check("wrap num_valid", 32'(NUM_VALID), 32'd1);
        go(1);
        check("end in start ignored", 32'(RUN_IN), 32'd1);

        // Reset mid-round.
        go(3);
        RST = 1'b1;
        go(1);
        RST = 1'b0;
        check("rst RUN_IN", 32'(RUN_IN), 32'd0);
        check("rst NUM", 32'(NUM), 32'd0);
        check("rst READY_Q", 32'(READY_Q), 32'd0);

        // Partial ready set across three ticks.
        READY = 2'b01;
        go(1);
        READY = 2'b00;
        go(28);
        check("partial held", 32'(READY_Q), 32'h1);
        go(1);
`ifdef READY_TIMEOUT_EN
        check("timeout pulse", 32'(TIMEOUT), 32'd1);
        check("partial dropped", 32'(READY_Q), 32'd0);
`else
        check("no timeout", 32'(TIMEOUT), 32'd0);
        check("partial kept", 32'(READY_Q), 32'h1);
`endif

        // Randomised traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            READY = {1'($urandom_range(0, 11) == 0), 1'($urandom_range(0, 11) == 0)};
            r = $urandom_range(0, 29);
            STATE = (r == 0) ? 4'hE : (r == 1) ? 4'hF : 4'($urandom_range(0, 13));
            RST = ($urandom_range(0, 799) == 0);
            go(1);
        end
        RST   = 1'b0;
        READY = 2'b00;
        STATE = 4'h0;
        go(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
